imm_enc: RTL and testbench

IMM_ENC -- requirements
Module: imm_enc

---
 rtl/imm_enc.sv | 124 ++++++++++++
 tb/tb_imm_enc.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/imm_enc.sv
// imm_enc: two-stage pipelined encoder that places an immediate into an instruction template.
// Ports: clk/rst_n (sync, active-low); in_valid/in_ready with imm_sel, imm and base_instr form the
// request side; out_valid/out_ready with instr and the err_* flags form the result side;
// err_cnt is a saturating count of delivered words that carry any error flag.
module imm_enc #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [2:0]   imm_sel,
  input  logic [W-1:0] imm,
  input  logic [W-1:0] base_instr,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] instr,
  output logic         err_range,
  output logic         err_align,
  output logic         err_sel,
  output logic [15:0]  err_cnt
);
  logic         s1_v_q, s1_v_d;
  logic [2:0]   s1_sel_q, s1_sel_d;
  logic [W-1:0] s1_imm_q, s1_imm_d, s1_base_q, s1_base_d;
  logic         out_valid_q, out_valid_d;
  logic [W-1:0] instr_q, instr_d;
  logic         rng_q, rng_d, aln_q, aln_d, sel_q, sel_d;
  logic [15:0]  cnt_q, cnt_d;
  logic [W-1:0] i, enc;
  logic         e_rng, e_aln, e_sel, ok12, ok13, ok21, s2_free, s2_ld, load;
  assign i = s1_imm_q;
  // A value fits in N signed bits when every bit from N-1 upward matches the sign.
  assign ok12 = &i[31:11] | ~|i[31:11];
  assign ok13 = &i[31:12] | ~|i[31:12];
  assign ok21 = &i[31:20] | ~|i[31:20];
  always_comb begin
    enc   = s1_base_q;
    e_rng = 1'b0;
    e_aln = 1'b0;
    e_sel = 1'b0;
    case (s1_sel_q)
      3'b001, 3'b100: begin
        enc[31:20] = i[11:0];
        e_rng      = !ok12;
      end
      3'b111: begin
        enc[31:25] = i[11:5];
        enc[11:7]  = i[4:0];
        e_rng      = !ok12;
      end
      3'b010: begin
        enc[31]    = i[12];
        enc[7]     = i[11];
        enc[30:25] = i[10:5];
        enc[11:8]  = i[4:1];
        e_rng      = !ok13;
        e_aln      = i[0];
      end
      3'b011: begin
        enc[31]    = i[20];
        enc[30:21] = i[10:1];
        enc[20]    = i[11];
        enc[19:12] = i[19:12];
        e_rng      = !ok21;
        e_aln      = i[0];
      end
      3'b101: begin
        enc[31:12] = i[31:12];
        e_aln      = |i[11:0];
      end
      3'b110: e_sel = 1'b1;
      default: ;
    endcase
  end
  always_comb begin
    s2_free     = !out_valid_q || out_ready;
    in_ready    = !s1_v_q || s2_free;
    load        = in_ready && in_valid;
    s2_ld       = s2_free && s1_v_q;
    s1_v_d      = in_ready ? in_valid : s1_v_q;
    s1_sel_d    = load ? imm_sel : s1_sel_q;
    s1_imm_d    = load ? imm : s1_imm_q;
    s1_base_d   = load ? base_instr : s1_base_q;
    out_valid_d = s2_free ? s1_v_q : out_valid_q;
    instr_d     = s2_ld ? enc : instr_q;
    rng_d       = s2_ld ? e_rng : rng_q;
    aln_d       = s2_ld ? e_aln : aln_q;
    sel_d       = s2_ld ? e_sel : sel_q;
    cnt_d       = (out_valid_q && out_ready && (rng_q | aln_q | sel_q) && cnt_q != 16'hFFFF)
                  ? cnt_q + 16'd1 : cnt_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_v_q      <= 1'b0;
      s1_sel_q    <= '0;
      s1_imm_q    <= '0;
      s1_base_q   <= '0;
      out_valid_q <= 1'b0;
      instr_q     <= '0;
      rng_q       <= 1'b0;
      aln_q       <= 1'b0;
      sel_q       <= 1'b0;
      cnt_q       <= '0;
    end else begin
      s1_v_q      <= s1_v_d;
      s1_sel_q    <= s1_sel_d;
      s1_imm_q    <= s1_imm_d;
      s1_base_q   <= s1_base_d;
      out_valid_q <= out_valid_d;
      instr_q     <= instr_d;
      rng_q       <= rng_d;
      aln_q       <= aln_d;
      sel_q       <= sel_d;
      cnt_q       <= cnt_d;
    end
  end
  assign out_valid = out_valid_q;
  assign instr     = instr_q;
  assign err_range = rng_q;
  assign err_align = aln_q;
  assign err_sel   = sel_q;
  assign err_cnt   = cnt_q;
endmodule

// File: tb/tb_imm_enc.sv
// tb_imm_enc: directed and random checks of imm_enc against a decode-based reference model.
module tb_imm_enc;
  logic        clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic [2:0]  imm_sel = '0;
  logic [31:0] imm = '0, base_instr = '0;
  logic        in_ready, out_valid, err_range, err_align, err_sel;
  logic [31:0] instr;
  logic [15:0] err_cnt;
  imm_enc #(.W(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .imm_sel(imm_sel),
    .imm(imm), .base_instr(base_instr), .out_valid(out_valid), .out_ready(out_ready),
    .instr(instr), .err_range(err_range), .err_align(err_align), .err_sel(err_sel),
    .err_cnt(err_cnt)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [2:0]  sel;
    logic [31:0] imm;
    logic [31:0] base;
    bit          lit;
    logic [31:0] li;
    logic [2:0]  lf;
  } ent_t;
  ent_t        q[$];
  int          pass_n = 0, tot_n = 0;
  logic [15:0] cnt_m = '0;
  bit          lit_en = 1'b0, held_v = 1'b0;
  logic [31:0] lit_i = '0, held_i;
  logic [2:0]  lit_f = '0, held_f;
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    tot_n++;
    if (act === exp) pass_n++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask
  function automatic logic [31:0] sext(logic [31:0] v, int n);
    logic [31:0] s;
    if (n == 0) return v;
    s = v << (32 - n);
    return 32'($signed(s) >>> (32 - n));
  endfunction
  function automatic int nbits(logic [2:0] s);
    return (s == 3'b001 || s == 3'b100 || s == 3'b111) ? 12 : s == 3'b010 ? 13 : s == 3'b011 ? 21 : 0;
  endfunction
  function automatic logic [31:0] field_mask(logic [2:0] s);
    return (s == 3'b001 || s == 3'b100) ? 32'hFFF00000 : (s == 3'b111 || s == 3'b010) ? 32'hFE000F80 :
           (s == 3'b011 || s == 3'b101) ? 32'hFFFFF000 : 32'h0;
  endfunction
  // Standard immediate decoder: the encoder must be its inverse.
  function automatic logic [31:0] dec(logic [31:0] x, logic [2:0] s);
    case (s)
      3'b001, 3'b100: return sext(32'(x[31:20]), 12);
      3'b111: return sext(32'({x[31:25], x[11:7]}), 12);
      3'b010: return sext(32'({x[31], x[7], x[30:25], x[11:8], 1'b0}), 13);
      3'b011: return sext(32'({x[31], x[19:12], x[20], x[30:21], 1'b0}), 21);
      3'b101: return {x[31:12], 12'h0};
      default: return x;
    endcase
  endfunction
  always @(negedge clk) begin
    ent_t        e;
    int          n;
    logic        er, ea, es;
    logic [31:0] v, m;
    if (!rst_n) begin
      q.delete();
      cnt_m  = '0;
      held_v = 1'b0;
    end else begin
      chk("in_ready", 32'(in_ready), 32'(!(q.size() == 2 && !out_ready)));
      chk("err_cnt", 32'(err_cnt), 32'(cnt_m));
      if (out_valid && !out_ready) begin
        if (held_v) begin
          chk("hold_instr", instr, held_i);
          chk("hold_flags", 32'({err_range, err_align, err_sel}), 32'(held_f));
        end
        held_v = 1'b1;
        held_i = instr;
        held_f = {err_range, err_align, err_sel};
      end else held_v = 1'b0;
      if (out_valid && out_ready) begin
        if (q.size() == 0) chk("spurious_out", 32'(out_valid), 32'h0);
        else begin
          e  = q.pop_front();
          n  = nbits(e.sel);
          er = n != 0 && sext(e.imm, n) != e.imm;
          ea = (e.sel == 3'b010 || e.sel == 3'b011) ? e.imm[0] : e.sel == 3'b101 ? (e.imm[11:0] != 0) : 1'b0;
          es = e.sel == 3'b110;
          v  = sext(e.imm, n);
          if (e.sel == 3'b010 || e.sel == 3'b011) v[0] = 1'b0;
          if (e.sel == 3'b101) v[11:0] = '0;
          m  = field_mask(e.sel);
          chk("model_flags", 32'({err_range, err_align, err_sel}), 32'({er, ea, es}));
          chk("model_keep", instr & ~m, e.base & ~m);
          if (m != 0) chk("model_decode", dec(instr, e.sel), v);
          if (e.lit) begin
            chk("lit_instr", instr, e.li);
            chk("lit_flags", 32'({err_range, err_align, err_sel}), 32'(e.lf));
          end
          if ((er | ea | es) && cnt_m != 16'hFFFF) cnt_m = cnt_m + 16'd1;
        end
      end
      if (in_valid && in_ready) q.push_back('{imm_sel, imm, base_instr, lit_en, lit_i, lit_f});
    end
  end
  task automatic send(logic [2:0] s, logic [31:0] im, logic [31:0] b, bit le, logic [31:0] li, logic [2:0] lf);
    bit acc = 1'b0;
    imm_sel = s; imm = im; base_instr = b; lit_en = le; lit_i = li; lit_f = lf; in_valid = 1'b1;
    for (int k = 0; k < 20 && !acc; k++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    lit_en   = 1'b0;
    if (!acc) chk("accept_timeout", 32'h0, 32'h1);
  endtask
  task automatic idle(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  initial begin
    logic [31:0] h, r;
    logic [2:0]  rs;
    idle(2);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_flags", 32'({err_range, err_align, err_sel}), 32'h0);
    chk("rst_err_cnt", 32'(err_cnt), 32'h0);
    chk("rst_in_ready", 32'(in_ready), 32'h1);
    @(posedge clk);
    #1;
    imm_sel = 3'b001; imm = 32'hFFFFFFFF; base_instr = 32'h13;
    lit_en = 1'b1; lit_i = 32'hFFF00013; lit_f = 3'b000; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0; lit_en = 1'b0;
    chk("lat_cycle1", 32'(out_valid), 32'h0);
    @(posedge clk);
    #1;
    chk("lat_cycle2", 32'(out_valid), 32'h1);
    chk("lat_instr", instr, 32'hFFF00013);
    send(3'b111, 32'h8,        32'h2023,     1, 32'h00002423, 3'b000);
    send(3'b010, 32'hFFFFF000, 32'h63,       1, 32'h80000063, 3'b000);
    send(3'b010, 32'h1000,     32'h63,       1, 32'h80000063, 3'b100);
    send(3'b101, 32'h12345000, 32'h37,       1, 32'h12345037, 3'b000);
    send(3'b101, 32'h12345001, 32'h37,       1, 32'h12345037, 3'b010);
    send(3'b010, 32'h3,        32'h63,       1, 32'h00000163, 3'b010);
    send(3'b110, 32'h5,        32'hDEADBEEF, 1, 32'hDEADBEEF, 3'b001);
    send(3'b000, 32'h5,        32'h00B50533, 1, 32'h00B50533, 3'b000);
    send(3'b011, 32'h800,      32'h6F,       1, 32'h0010006F, 3'b000);
    send(3'b100, 32'hFFFFF800, 32'h67,       1, 32'h80000067, 3'b000);
    send(3'b111, 32'h800,      32'h23,       1, 32'h80000023, 3'b100);
    for (int k = 0; k < 24; k++) begin
      rs = 3'($urandom_range(0, 7));
      r  = $urandom;
      if ($urandom_range(0, 1) == 1) r = sext(r, $urandom_range(8, 22));
      if ($urandom_range(0, 1) == 1) r[0] = 1'b0;
      send(rs, r, $urandom, 0, 32'h0, 3'b000);
    end
    idle(4);
    out_ready = 1'b0;
    send(3'b101, 32'h12345000, 32'h37,   1, 32'h12345037, 3'b000);
    send(3'b111, 32'h8,        32'h2023, 1, 32'h00002423, 3'b000);
    @(negedge clk);
    chk("bp_full", 32'(in_ready), 32'h0);
    h = instr;
    repeat (5) begin
      @(negedge clk);
      chk("bp_hold", instr, h);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_first", {31'h0, out_valid} ^ instr, 32'h12345036);
    @(negedge clk);
    chk("bp_second_v", 32'(out_valid), 32'h1);
    chk("bp_second", instr, 32'h00002423);
    @(negedge clk);
    chk("bp_empty", 32'(out_valid), 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    idle(1);
    rst_n = 1'b1;
    send(3'b010, 32'h1000,     32'h63, 0, 32'h0, 3'b000);
    send(3'b101, 32'h12345001, 32'h37, 0, 32'h0, 3'b000);
    send(3'b110, 32'h0,        32'h13, 0, 32'h0, 3'b000);
    idle(4);
    @(negedge clk);
    chk("cnt_three", 32'(err_cnt), 32'h3);
    @(posedge clk);
    #1;
    force dut.cnt_q = 16'hFFFF;
    cnt_m = 16'hFFFF;
    #1;
    release dut.cnt_q;
    send(3'b110, 32'h0, 32'h13, 0, 32'h0, 3'b000);
    idle(4);
    @(negedge clk);
    chk("cnt_sat", 32'(err_cnt), 32'hFFFF);
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    send(3'b001, 32'h1, 32'h13, 0, 32'h0, 3'b000);
    send(3'b001, 32'h2, 32'h13, 0, 32'h0, 3'b000);
    rst_n = 1'b0;
    idle(1);
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_rst_valid", 32'(out_valid), 32'h0);
    chk("mid_rst_cnt", 32'(err_cnt), 32'h0);
    chk("mid_rst_ready", 32'(in_ready), 32'h1);
    out_ready = 1'b1;
    repeat (6) begin
      @(negedge clk);
      chk("post_rst_quiet", 32'(out_valid), 32'h0);
    end
    $display("%0d/%0d checks passed", pass_n, tot_n);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1);
  end
endmodule
